// File: rtl/dmem_responder_if.sv
// Memory-side request/response bundle between the MIPS control unit and the data memory.
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;

  // Core side: issues lw/sw requests and holds them until done.
  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, done, err, stall
  );

  // Memory side: accepts one access at a time and reports completion.
  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, done, err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states, one access in flight,
// a one-cycle done/err completion pulse and a combinational pipeline stall.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  dmem_responder_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [DATA_W-1:0]       cap_wdata;
  logic                    cap_wr;
  logic                    cap_err;
  logic [DATA_W-1:0]       rdata_q;
  logic                    done_q;
  logic                    err_q;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    req_c;
  logic                    acc_err_c;
  logic                    from_idle_c;
  logic                    fire_c;
  logic [ADDR_WIDTH-1:0]   op_idx_c;
  logic [DATA_W-1:0]       op_wdata_c;
  logic                    op_wr_c;
  logic                    op_err_c;
  logic                    mem_we_c;

  // Access operands: live inputs for a zero-wait access, captured copies otherwise.
  always_comb begin
    req_c       = bus.mem_read | bus.mem_write;
    acc_err_c   = (bus.addr[1:0] != 2'b00) | (bus.mem_read & bus.mem_write);
    from_idle_c = (state == S_IDLE) && req_c && (WAIT_CYCLES == 0);
    fire_c      = from_idle_c || ((state == S_WAIT) && (cnt == CNT_W'(1)));
    op_idx_c    = cap_idx;
    op_wdata_c  = cap_wdata;
    op_wr_c     = cap_wr;
    op_err_c    = cap_err;
    if (from_idle_c) begin
      op_idx_c   = bus.addr[ADDR_WIDTH+1:2];
      op_wdata_c = bus.wdata;
      op_wr_c    = bus.mem_write;
      op_err_c   = acc_err_c;
    end
    mem_we_c = fire_c & op_wr_c & ~op_err_c;
  end

  // Sequencer: accept, count wait states, complete; outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
      cap_err   <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            cap_idx   <= bus.addr[ADDR_WIDTH+1:2];
            cap_wdata <= bus.wdata;
            cap_wr    <= bus.mem_write;
            cap_err   <= acc_err_c;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (fire_c) begin
        done_q <= 1'b1;
        err_q  <= op_err_c;
        if (!op_err_c && !op_wr_c) begin
          rdata_q <= mem[op_idx_c];
        end
      end
    end
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[op_idx_c] <= op_wdata_c;
    end
  end

  // Stall releases in the done cycle so the core advances on the edge that ends it.
  always_comb begin
    bus.rdata = rdata_q;
    bus.done  = done_q;
    bus.err   = err_q;
    bus.stall = req_c & ~done_q;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS datapath. It is the memory-side end of the `mem_read` / `mem_write` interface that the control unit drives for `lw` / `sw`. It services one word access at a time with a programmable number of wait states and returns a one-cycle `done` pulse plus read data. While an access is outstanding it drives a combinational `stall` that freezes the PC and pipeline registers.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-index width; memory holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: extra cycles between accept and completion; legal range 0–15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request from the control unit (`lw`).
- `mem_write` input 1: write request from the control unit (`sw`).
- `addr` input 32: byte address from the ALU result.
- `wdata` input 32: store data (rt register value).
- `rdata` output 32: load data; valid while `done` is 1; held until the next successful read completes.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: qualifies `done`; 1 means the request was rejected and no memory access occurred.
- `stall` output 1: combinational; equals (`mem_read` | `mem_write`) & ~`done`.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - If `mem_read` | `mem_write` is 1 at an edge, the request is accepted: `addr`, `wdata`, and request type are captured into internal registers, and the wait counter is loaded with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, else DONE.
- WAIT:
  - The counter decrements each edge.
  - On the edge where the counter equals 1, the state moves to DONE and the access is performed.
  - Input changes during WAIT are ignored; only the captured values are used.
- DONE:
  - `done` = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - A request present in the following IDLE cycle is treated as a new request.
- Access, performed on the edge entering DONE:
  - Word index = captured `addr[ADDR_WIDTH+1:2]`; upper address bits are ignored, so the address space wraps modulo 2^ADDR_WIDTH words.
  - Write: `mem[idx]` ← captured `wdata`; `rdata` is unchanged.
  - Read: `rdata` ← `mem[idx]`.
- Errors (decided at accept; the request still walks through WAIT so latency is uniform):
  - Misaligned: captured `addr[1:0]` != 0.
  - Conflict: `mem_read` and `mem_write` both 1.
  - On error: no memory access; `rdata` unchanged; `err` = 1 during the DONE cycle.
- `err` is 0 whenever `done` is 0.
- Memory array contents are not reset. Their value before the first write is undefined, and the bench must not check it.

## Timing
- Reset values:
  - State: IDLE; counter: 0.
  - `done` = 0, `err` = 0, `rdata` = 32'h0.
  - `stall` follows its combinational definition.
- Reset asserted mid-access aborts the access: a pending write is not committed, and `rdata` is cleared to 0.
- Latency:
  - A request first visible in cycle N gets `done` in cycle N + WAIT_CYCLES + 1.
  - `stall` is 1 in cycles N through N + WAIT_CYCLES and 0 in the `done` cycle, so the core advances on the edge that ends the `done` cycle.
- Back-to-back accesses: each costs WAIT_CYCLES + 2 cycles (the DONE cycle followed by one IDLE cycle).
- No request: `stall` = 0 and the block stays in IDLE.
- `done` and `err` are registered outputs; `rdata` is a registered output.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles, then high, no requests. Required: `done` = 0, `err` = 0, `rdata` = 0, `stall` = 0 throughout.
- Write/read with `WAIT_CYCLES` = 2:
  - Request: `sw` `addr` = 0x10, `wdata` = 0xDEADBEEF, then `lw` `addr` = 0x10.
  - Required: each access has `done` exactly 3 cycles after the request appears and `stall` high for 3 cycles.
  - The read returns `rdata` = 0xDEADBEEF with `err` = 0.
- Wrap-around with `ADDR_WIDTH` = 8:
  - Request: `sw` to 0x400 with data 0x12345678, then `lw` from 0x000.
  - Required: the read returns 0x12345678.
- Errors:
  - `lw` at 0x13 → `done` and `err` both 1; `rdata` keeps its previous value.
  - `mem_read` = `mem_write` = 1 at 0x20 → `err` = 1; a following `lw` from 0x20 shows no write occurred.
- Reset mid-access:
  - Stimulus: `sw` 0xA5A5A5A5 to 0x40, with `rst_n` pulsed low during WAIT.
  - Required: no `done`; outputs return to reset values.
  - A subsequent `sw` 0x1 to 0x40 followed by `lw` 0x40 returns 0x1.
- Zero-wait and input churn:
  - With `WAIT_CYCLES` = 0: `lw` gets `done` in the next cycle.
  - With `WAIT_CYCLES` = 3: changing `addr` and `wdata` during WAIT has no effect on the committed address or data.
